// File: rtl/ysyx_22050612_mem_arbiter.sv
// Two-requester (fetch / load-store) arbiter onto a single memory port, one transaction in flight.
// Define YSYX_22050612_ARB_RR_EN for round-robin selection; default is fixed LSU-over-IFU priority.
module ysyx_22050612_mem_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req_valid,
  output logic        if_req_ready,
  input  logic [63:0] if_addr,
  output logic        if_rsp_valid,
  output logic [63:0] if_rdata,
  input  logic        ls_req_valid,
  output logic        ls_req_ready,
  input  logic        ls_wen,
  input  logic [63:0] ls_addr,
  input  logic [63:0] ls_wdata,
  input  logic [7:0]  ls_wmask,
  output logic        ls_rsp_valid,
  output logic [63:0] ls_rdata,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic        mem_wen,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  output logic [7:0]  mem_wmask,
  input  logic        mem_rsp_valid,
  input  logic [63:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_LS = 2'd2
  } state_e;

  localparam logic OWNER_IF = 1'b0;
  localparam logic OWNER_LS = 1'b1;

  state_e state_r;
  state_e state_nxt_s;
  logic   last_owner_r;
  logic   sel_ls_s;
  logic   any_req_s;
  logic   accept_s;

  assign any_req_s = if_req_valid | ls_req_valid;
  assign accept_s  = (state_r == IDLE) & any_req_s & mem_req_ready;

  // Requester selection for the current IDLE cycle
  always_comb begin
    sel_ls_s = 1'b0;
`ifdef YSYX_22050612_ARB_RR_EN
    if (if_req_valid && ls_req_valid) begin
      sel_ls_s = (last_owner_r == OWNER_IF);
    end else begin
      sel_ls_s = ls_req_valid;
    end
`else
    sel_ls_s = ls_req_valid;
`endif
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Last granted requester, kept in both builds
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_owner_r <= OWNER_IF;
    end else if (accept_s) begin
      last_owner_r <= sel_ls_s ? OWNER_LS : OWNER_IF;
    end else begin
      last_owner_r <= last_owner_r;
    end
  end

  // Next-state logic; a response seen in IDLE is stale and ignored
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_nxt_s = sel_ls_s ? BUSY_LS : BUSY_IF;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      BUSY_IF: begin
        if (mem_rsp_valid) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = BUSY_IF;
        end
      end
      BUSY_LS: begin
        if (mem_rsp_valid) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = BUSY_LS;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Output logic; everything held quiet while reset is asserted
  always_comb begin
    if_req_ready  = 1'b0;
    ls_req_ready  = 1'b0;
    if_rsp_valid  = 1'b0;
    ls_rsp_valid  = 1'b0;
    if_rdata      = 64'd0;
    ls_rdata      = 64'd0;
    mem_req_valid = 1'b0;
    mem_wen       = 1'b0;
    mem_addr      = 64'd0;
    mem_wdata     = 64'd0;
    mem_wmask     = 8'd0;
    if (rst) begin
      mem_req_valid = 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          mem_req_valid = any_req_s;
          if (sel_ls_s) begin
            mem_wen      = ls_wen;
            mem_addr     = ls_addr;
            mem_wdata    = ls_wdata;
            mem_wmask    = ls_wmask;
            ls_req_ready = mem_req_ready & ls_req_valid;
          end else begin
            mem_wen      = 1'b0;
            mem_addr     = if_addr;
            mem_wdata    = 64'd0;
            mem_wmask    = 8'd0;
            if_req_ready = mem_req_ready & if_req_valid;
          end
        end
        BUSY_IF: begin
          if_rsp_valid = mem_rsp_valid;
          if_rdata     = mem_rdata;
        end
        BUSY_LS: begin
          ls_rsp_valid = mem_rsp_valid;
          ls_rdata     = mem_rdata;
        end
        default: begin
          mem_req_valid = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_22050612_mem_arbiter.sv
// Scoreboard bench for ysyx_22050612_mem_arbiter: directed requests, a latency-programmable
// memory model, and a monitor that checks grants and responses against expected queues.
module tb_ysyx_22050612_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req_valid, if_req_ready, if_rsp_valid;
  logic [63:0] if_addr, if_rdata;
  logic        ls_req_valid, ls_req_ready, ls_wen, ls_rsp_valid;
  logic [63:0] ls_addr, ls_wdata, ls_rdata;
  logic [7:0]  ls_wmask;
  logic        mem_req_valid, mem_req_ready, mem_wen, mem_rsp_valid;
  logic [63:0] mem_addr, mem_wdata, mem_rdata;
  logic [7:0]  mem_wmask;

  always #5 clk = ~clk;

  ysyx_22050612_mem_arbiter dut (
    .clk(clk), .rst(rst),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_addr(if_addr),
    .if_rsp_valid(if_rsp_valid), .if_rdata(if_rdata),
    .ls_req_valid(ls_req_valid), .ls_req_ready(ls_req_ready), .ls_wen(ls_wen),
    .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_wmask(ls_wmask),
    .ls_rsp_valid(ls_rsp_valid), .ls_rdata(ls_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_wen(mem_wen),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata)
  );

  typedef struct packed {
    logic        is_ls;
    logic        wen;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [7:0]  wmask;
  } grant_t;

  typedef struct packed {
    logic        is_ls;
    logic [63:0] data;
  } rsp_t;

  grant_t grant_q[$];
  rsp_t   rsp_q[$];
  int     total = 0;
  int     bad   = 0;
  int     cyc   = 0;
  int     last_rsp_cyc = 0;
  bit     rsp_seen = 1'b0;
  bit     b2b_chk  = 1'b0;
  bit     chk_stall = 1'b0;
  bit     saw_mrsp = 1'b0;
  int     mem_lat = 1;
  int     stall   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] mem_data(input logic [63:0] a);
    if (a == 64'h0000_0000_8000_0000) return 64'h0000_0000_0000_0013;
    else return ~a;
  endfunction

  // Memory model: accepts at the edge following a valid&ready sample, replies mem_lat cycles later
  initial begin : mem_model
    logic        mbusy;
    int          mcnt;
    logic [63:0] mdata;
    logic        hs;
    logic [63:0] a;
    mem_req_ready = 1'b1;
    mem_rsp_valid = 1'b0;
    mem_rdata     = 64'd0;
    mbusy = 1'b0;
    mcnt  = 0;
    mdata = 64'd0;
    forever begin
      @(negedge clk);
      hs = mem_req_valid & mem_req_ready & ~rst;
      a  = mem_addr;
      if (mem_rsp_valid) saw_mrsp = 1'b1;
      if (mem_req_valid && stall > 0) stall--;
      @(posedge clk);
      #1;
      mem_rsp_valid = 1'b0;
      mem_rdata     = 64'd0;
      if (mbusy) begin
        if (mcnt == 0) begin
          mem_rsp_valid = 1'b1;
          mem_rdata     = mdata;
          mbusy         = 1'b0;
        end else begin
          mcnt--;
        end
      end
      if (hs) begin
        mbusy = 1'b1;
        mcnt  = mem_lat - 1;
        mdata = mem_data(a);
      end
      mem_req_ready = (stall == 0);
    end
  end

  // Monitor: pops expected grants/responses whenever the DUT presents them
  initial begin : monitor
    grant_t g;
    rsp_t   r;
    forever begin
      @(negedge clk);
      if (rst) begin
        check64("rst_outputs", {59'd0, if_req_ready, ls_req_ready, if_rsp_valid, ls_rsp_valid, mem_req_valid}, 64'd0);
      end else begin
        if (mem_req_valid && mem_req_ready) begin
          if (grant_q.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_grant: got addr %h expected no grant", mem_addr);
          end else begin
            g = grant_q.pop_front();
            check64("grant_owner", {62'd0, if_req_ready, ls_req_ready}, g.is_ls ? 64'd1 : 64'd2);
            check64("grant_addr", mem_addr, g.addr);
            check64("grant_wen", {63'd0, mem_wen}, {63'd0, g.wen});
            check64("grant_wmask", {56'd0, mem_wmask}, {56'd0, g.wmask});
            if (g.is_ls) check64("grant_wdata", mem_wdata, g.wdata);
            if (b2b_chk && rsp_seen) check64("grant_gap", 64'(cyc), 64'(last_rsp_cyc + 1));
          end
        end
        if (if_req_ready || ls_req_ready)
          check64("ready_needs_mem", {63'd0, mem_req_ready & mem_req_valid}, 64'd1);
        if (if_rsp_valid || ls_rsp_valid) begin
          if (rsp_q.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_rsp: got if=%0b ls=%0b expected none", if_rsp_valid, ls_rsp_valid);
          end else begin
            r = rsp_q.pop_front();
            check64("rsp_owner", {62'd0, if_rsp_valid, ls_rsp_valid}, r.is_ls ? 64'd1 : 64'd2);
            check64("rsp_data", r.is_ls ? ls_rdata : if_rdata, r.data);
          end
          last_rsp_cyc = cyc;
          rsp_seen = 1'b1;
        end
      end
    end
  end

  task automatic req_if(input logic [63:0] a);
    bit got;
    got = 1'b0;
    if_req_valid = 1'b1;
    if_addr = a;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (if_req_ready) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      total++; bad++;
      $display("FAIL if_timeout: got no if_req_ready expected grant for %h", a);
    end
    @(posedge clk);
    #1;
    if_req_valid = 1'b0;
  endtask

  task automatic req_ls(input logic w, input logic [63:0] a, input logic [63:0] d, input logic [7:0] m);
    bit got;
    int waits;
    got = 1'b0;
    waits = 0;
    ls_req_valid = 1'b1;
    ls_wen = w; ls_addr = a; ls_wdata = d; ls_wmask = m;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (ls_req_ready) begin
        got = 1'b1;
        break;
      end
      waits++;
      if (chk_stall) begin
        check64("stall_valid", {63'd0, mem_req_valid}, 64'd1);
        check64("stall_addr", mem_addr, a);
        check64("stall_wdata", mem_wdata, d);
      end
    end
    if (!got) begin
      total++; bad++;
      $display("FAIL ls_timeout: got no ls_req_ready expected grant for %h", a);
    end
    if (chk_stall) check64("stall_cycles", 64'(waits), 64'd2);
    @(posedge clk);
    #1;
    ls_req_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 100; i++) begin
      if (grant_q.size() == 0 && rsp_q.size() == 0) break;
      @(posedge clk);
    end
    check64("queues_drained", 64'(grant_q.size() + rsp_q.size()), 64'd0);
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    rsp_seen = 1'b0;
  endtask

  function automatic grant_t mk_g(input logic l, input logic w, input logic [63:0] a,
                                  input logic [63:0] d, input logic [7:0] m);
    grant_t g;
    g.is_ls = l; g.wen = w; g.addr = a; g.wdata = d; g.wmask = m;
    return g;
  endfunction

  function automatic rsp_t mk_r(input logic l, input logic [63:0] d);
    rsp_t r;
    r.is_ls = l; r.data = d;
    return r;
  endfunction

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: got no finish expected completion");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "timeout");
  end

  initial begin : stim
    rst = 1'b1;
    if_req_valid = 1'b1; if_addr = 64'h0000_0000_8000_0000;
    ls_req_valid = 1'b1; ls_wen = 1'b1; ls_addr = 64'h0000_0000_8000_0100;
    ls_wdata = 64'd0; ls_wmask = 8'hff;
    repeat (3) @(negedge clk);
    if_req_valid = 1'b0;
    ls_req_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Fetch only, 3-cycle memory latency
    mem_lat = 3;
    grant_q.push_back(mk_g(1'b0, 1'b0, 64'h0000_0000_8000_0000, 64'd0, 8'd0));
    rsp_q.push_back(mk_r(1'b0, 64'h0000_0000_0000_0013));
    req_if(64'h0000_0000_8000_0000);
    drain();

    // Simultaneous fetch and load from reset: LSU first, fetch right after the response
    do_reset();
    mem_lat = 1;
    b2b_chk = 1'b1;
    grant_q.push_back(mk_g(1'b1, 1'b0, 64'h0000_0000_8000_1000, 64'd0, 8'd0));
    grant_q.push_back(mk_g(1'b0, 1'b0, 64'h0000_0000_8000_2000, 64'd0, 8'd0));
    rsp_q.push_back(mk_r(1'b1, ~64'h0000_0000_8000_1000));
    rsp_q.push_back(mk_r(1'b0, ~64'h0000_0000_8000_2000));
    fork
      req_if(64'h0000_0000_8000_2000);
      req_ls(1'b0, 64'h0000_0000_8000_1000, 64'd0, 8'd0);
    join
    drain();

    // Both requesters held continuously for four transactions each
    do_reset();
`ifdef YSYX_22050612_ARB_RR_EN
    for (int k = 0; k < 4; k++) begin
      grant_q.push_back(mk_g(1'b1, 1'b0, 64'h0000_0000_8000_4000 + 64'(k * 8), 64'd0, 8'd0));
      rsp_q.push_back(mk_r(1'b1, ~(64'h0000_0000_8000_4000 + 64'(k * 8))));
      grant_q.push_back(mk_g(1'b0, 1'b0, 64'h0000_0000_8000_3000 + 64'(k * 8), 64'd0, 8'd0));
      rsp_q.push_back(mk_r(1'b0, ~(64'h0000_0000_8000_3000 + 64'(k * 8))));
    end
`else
    for (int k = 0; k < 4; k++) begin
      grant_q.push_back(mk_g(1'b1, 1'b0, 64'h0000_0000_8000_4000 + 64'(k * 8), 64'd0, 8'd0));
      rsp_q.push_back(mk_r(1'b1, ~(64'h0000_0000_8000_4000 + 64'(k * 8))));
    end
    for (int k = 0; k < 4; k++) begin
      grant_q.push_back(mk_g(1'b0, 1'b0, 64'h0000_0000_8000_3000 + 64'(k * 8), 64'd0, 8'd0));
      rsp_q.push_back(mk_r(1'b0, ~(64'h0000_0000_8000_3000 + 64'(k * 8))));
    end
`endif
    fork
      begin
        for (int k = 0; k < 4; k++) req_if(64'h0000_0000_8000_3000 + 64'(k * 8));
      end
      begin
        for (int j = 0; j < 4; j++) req_ls(1'b0, 64'h0000_0000_8000_4000 + 64'(j * 8), 64'd0, 8'd0);
      end
    join
    drain();
    b2b_chk = 1'b0;

    // Store with memory port stalled for two cycles
    do_reset();
    mem_lat = 2;
    chk_stall = 1'b1;
    stall = 2;
    mem_req_ready = 1'b0;
    grant_q.push_back(mk_g(1'b1, 1'b1, 64'h0000_0000_8000_5000, 64'h0000_0000_8000_6000, 8'hff));
    rsp_q.push_back(mk_r(1'b1, ~64'h0000_0000_8000_5000));
    req_ls(1'b1, 64'h0000_0000_8000_5000, 64'h0000_0000_8000_6000, 8'hff);
    chk_stall = 1'b0;
    drain();

    // Reset during BUSY_LS; the late response must be dropped
    do_reset();
    mem_lat = 3;
    grant_q.push_back(mk_g(1'b1, 1'b0, 64'h0000_0000_8000_7000, 64'd0, 8'd0));
    req_ls(1'b0, 64'h0000_0000_8000_7000, 64'd0, 8'd0);
    rst = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    saw_mrsp = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check64("abandon_rsp", {62'd0, if_rsp_valid, ls_rsp_valid}, 64'd0);
    end
    check64("abandon_mem_rsp_seen", {63'd0, saw_mrsp}, 64'd1);
    @(posedge clk);
    #1;
    grant_q.push_back(mk_g(1'b0, 1'b0, 64'h0000_0000_8000_8000, 64'd0, 8'd0));
    rsp_q.push_back(mk_r(1'b0, ~64'h0000_0000_8000_8000));
    req_if(64'h0000_0000_8000_8000);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
